perf_report_sequencer: RTL and testbench

- Sequences dumping of the cache performance counters over the UART transmitter once the CPU signals completion.
- On a cpu_done rising edge it snapshots all counter values, then streams a framed byte sequence to the TX byte interface, one byte per TX handshake.
- Frame: header byte, counter bytes MSB-first in counter-index order, XOR checksum byte.
- Sits between the performance counter bank and the UART TX, replacing direct counter-to-TX start wiring.

---
 rtl/perf_report_pkg.sv | 42 ++++
 rtl/perf_report_sequencer.sv | 137 +++++++++++++
 tb/tb_perf_report_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/perf_report_pkg.sv
// rtl/perf_report_pkg.sv - shared types, defaults and byte selection for the performance report sequencer
package perf_report_pkg;

  // Default geometry of the counter bank and the frame start marker
  localparam int         DEF_NUM_CNT = 8;
  localparam int         DEF_CNT_W   = 32;
  localparam logic [7:0] DEF_HEADER  = 8'hA5;

  // Widest snapshot the byte selector accepts; narrower snapshots are zero-extended
  localparam int         SNAP_MAX_W  = 4096;

  // Report FSM states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR    = 3'd1,
    WAIT_H = 3'd2,
    LOAD   = 3'd3,
    WAIT_P = 3'd4,
    CSUM   = 3'd5,
    WAIT_C = 3'd6
  } state_e;

  // Payload byte idx of the snapshot: counters in index order, each counter MSB byte first.
  // Counter k lives at bits [k*cnt_w +: cnt_w]; byte j of that counter (0 = MSB) sits
  // 8*j bits below its top byte.
  function automatic logic [7:0] payload_byte(
    input logic [SNAP_MAX_W-1:0] snap,
    input int unsigned           cnt_w,
    input int unsigned           idx
  );
    int unsigned bytes_per_cnt;
    int unsigned cnt_sel;
    int unsigned byte_sel;
    int unsigned bit_off;
    bytes_per_cnt = cnt_w / 8;
    cnt_sel       = idx / bytes_per_cnt;
    byte_sel      = idx % bytes_per_cnt;
    bit_off       = cnt_sel * cnt_w + (cnt_w - 8) - 8 * byte_sel;
    return snap[bit_off +: 8];
  endfunction

endpackage

// File: rtl/perf_report_sequencer.sv
// rtl/perf_report_sequencer.sv - snapshots the counter bank on cpu_done and streams a framed report to UART TX
module perf_report_sequencer
  import perf_report_pkg::*;
#(
  parameter int         NUM_CNT = DEF_NUM_CNT,
  parameter int         CNT_W   = DEF_CNT_W,
  parameter logic [7:0] HEADER  = DEF_HEADER
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_done,
  input  logic [NUM_CNT*CNT_W-1:0] cnt_flat,
  input  logic                     tx_done,
  output logic [7:0]               tx_din,
  output logic                     tx_start,
  output logic                     busy,
  output logic                     report_done
);

  localparam int SNAP_W = NUM_CNT * CNT_W;
  localparam int NB     = SNAP_W / 8;
  localparam int IDX_W  = $clog2(NB + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_e              state_q;
  logic [SNAP_W-1:0]   snap_q;
  logic [IDX_W-1:0]    idx_q;
  logic [7:0]          checksum_q;
  logic                cpu_done_q;
  logic [7:0]          tx_din_q;
  logic                tx_start_q;
  logic                busy_q;
  logic                report_done_q;

  logic                trigger;
  logic [SNAP_MAX_W-1:0] snap_ext;
  logic [7:0]          cur_byte;
  logic [7:0]          checksum_d;

  // Rising-edge detector on cpu_done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_done_q <= 1'b0;
    end else begin
      cpu_done_q <= cpu_done;
    end
  end

  assign trigger = cpu_done & ~cpu_done_q;

  // Byte selection from the frozen snapshot and the running checksum update
  always_comb begin
    snap_ext             = '0;
    snap_ext[SNAP_W-1:0] = snap_q;
    cur_byte             = payload_byte(snap_ext, CNT_W, 32'(idx_q));
    checksum_d           = checksum_q ^ cur_byte;
  end

  // Report FSM: every output is registered so tx_start/tx_din appear one cycle after
  // entering HDR, LOAD or CSUM. A trigger landing in the report_done cycle is dropped even
  // though the state is already IDLE, so back-to-back reports always need a fresh edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      snap_q        <= '0;
      idx_q         <= '0;
      checksum_q    <= '0;
      tx_din_q      <= '0;
      tx_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      report_done_q <= 1'b0;
    end else begin
      tx_start_q    <= 1'b0;
      report_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (trigger && !report_done_q) begin
            snap_q     <= cnt_flat;
            busy_q     <= 1'b1;
            checksum_q <= '0;
            idx_q      <= '0;
            state_q    <= HDR;
          end
        end
        HDR: begin
          tx_din_q   <= HEADER;
          tx_start_q <= 1'b1;
          state_q    <= WAIT_H;
        end
        WAIT_H: begin
          if (tx_done) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          tx_din_q   <= cur_byte;
          tx_start_q <= 1'b1;
          checksum_q <= checksum_d;
          state_q    <= WAIT_P;
        end
        WAIT_P: begin
          if (tx_done) begin
            if (idx_q == LAST_IDX) begin
              state_q <= CSUM;
            end else begin
              idx_q   <= idx_q + IDX_ONE;
              state_q <= LOAD;
            end
          end
        end
        CSUM: begin
          tx_din_q   <= checksum_q;
          tx_start_q <= 1'b1;
          state_q    <= WAIT_C;
        end
        WAIT_C: begin
          if (tx_done) begin
            busy_q        <= 1'b0;
            report_done_q <= 1'b1;
            state_q       <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_din      = tx_din_q;
  assign tx_start    = tx_start_q;
  assign busy        = busy_q;
  assign report_done = report_done_q;

endmodule

// File: tb/tb_perf_report_sequencer.sv
// tb/tb_perf_report_sequencer.sv - self-checking bench for perf_report_sequencer
module tb_perf_report_sequencer;

  localparam int NUM_CNT = 8;
  localparam int CNT_W   = 32;
  localparam int NB      = NUM_CNT * CNT_W / 8;

  typedef struct packed {
    logic [NUM_CNT-1:0][CNT_W-1:0] cnt;
    logic [7:0]                    exp_csum;
    logic                          rnd_delay;
  } vec_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     cpu_done;
  logic [NUM_CNT*CNT_W-1:0] cnt_flat;
  logic                     tx_done;
  logic [7:0]               tx_din;
  logic                     tx_start;
  logic                     busy;
  logic                     report_done;

  always #5 clk = ~clk;

  perf_report_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_done    (cpu_done),
    .cnt_flat    (cnt_flat),
    .tx_done     (tx_done),
    .tx_din      (tx_din),
    .tx_start    (tx_start),
    .busy        (busy),
    .report_done (report_done)
  );

  int passed = 0;
  int total  = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int start_cnt, rd_cnt, stable_err, gap_err, busy_err, align_err;
  int tx_delay  = 10;
  bit rand_delay = 1'b0;
  int long_idx  = -1;
  bit spur_req  = 1'b0;
  bit tx_flush  = 1'b0;

  task automatic check(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Reference model: frame = header, each counter shifted out MSB byte first, XOR of payload
  function automatic logic [7:0] build_exp(input logic [NUM_CNT-1:0][CNT_W-1:0] c);
    logic [7:0]  cs;
    logic [31:0] v;
    cs = 8'h00;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int k = 0; k < NUM_CNT; k++) begin
      v = c[k];
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(v[31:24]);
        cs = cs ^ v[31:24];
        v  = v << 8;
      end
    end
    exp_q.push_back(cs);
    return cs;
  endfunction

  // TX model and protocol monitor
  initial begin
    bit         pending;
    int         left;
    int         since_done;
    bit         prev_busy;
    logic [7:0] held;
    pending = 0; left = 0; since_done = 100; prev_busy = 0; held = '0;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      since_done++;
      if (tx_flush) begin
        pending  = 0;
        tx_flush = 0;
      end
      if (report_done) begin
        rd_cnt++;
        if (busy || !prev_busy) align_err++;
      end
      prev_busy = busy;
      if (pending) begin
        if (tx_din !== held) stable_err++;
        if (!busy) busy_err++;
        left--;
        if (left <= 0) begin
          tx_done    = 1'b1;
          pending    = 0;
          since_done = 0;
        end
      end
      if (tx_start) begin
        rx_q.push_back(tx_din);
        if (pending || since_done < 2) gap_err++;
        if (!busy) busy_err++;
        pending = 1;
        held    = tx_din;
        if (start_cnt == long_idx) left = 1000;
        else if (rand_delay)       left = $urandom_range(1, 12);
        else                       left = tx_delay;
        start_cnt++;
      end
      if (spur_req) begin
        tx_done  = 1'b1;
        spur_req = 0;
      end
    end
  end

  task automatic clear_stats();
    rx_q.delete();
    start_cnt = 0; rd_cnt = 0; stable_err = 0; gap_err = 0; busy_err = 0; align_err = 0;
  endtask

  task automatic trig(input logic [NUM_CNT*CNT_W-1:0] c);
    @(negedge clk);
    cnt_flat = c;
    cpu_done = 1'b1;
    @(negedge clk);
    cpu_done = 1'b0;
  endtask

  task automatic wait_report(input string nm, input int bound, input bit scramble);
    int n;
    int start;
    n = 0;
    start = rd_cnt;
    while (rd_cnt == start && n < bound) begin
      @(negedge clk);
      if (scramble) cnt_flat = {$urandom, $urandom, $urandom, $urandom,
                                $urandom, $urandom, $urandom, $urandom};
      n++;
    end
    check(n < bound, {nm, "_report_in_time"}, n, bound);
    repeat (20) @(negedge clk);
  endtask

  function automatic logic [8:0] rx_at(input int i);
    if (i < rx_q.size()) return {1'b0, rx_q[i]};
    return 9'h100;
  endfunction

  task automatic check_frame(input string nm, input logic [NUM_CNT-1:0][CNT_W-1:0] c,
                             input logic [7:0] exp_csum);
    int bad;
    void'(build_exp(c));
    bad = 0;
    check(rx_q.size() == NB + 2, {nm, "_len"}, rx_q.size(), NB + 2);
    check(rx_at(0) == 9'h0A5, {nm, "_header"}, rx_at(0), 9'h0A5);
    for (int i = 1; i <= NB; i++)
      if (rx_at(i) != {1'b0, exp_q[i]}) bad++;
    check(bad == 0, {nm, "_payload_bad_bytes"}, bad, 0);
    check(rx_at(NB + 1) == {1'b0, exp_csum}, {nm, "_checksum"}, rx_at(NB + 1), exp_csum);
    check(rd_cnt == 1, {nm, "_report_done_pulses"}, rd_cnt, 1);
    check(stable_err + gap_err + busy_err + align_err == 0, {nm, "_protocol_errors"},
          {stable_err[7:0], gap_err[7:0], busy_err[7:0], align_err[7:0]}, 0);
    check(busy == 1'b0, {nm, "_busy_after"}, busy, 0);
  endtask

  initial begin
    vec_t vecs[6];
    logic [NUM_CNT-1:0][CNT_W-1:0] c;
    int n;

    rst = 1'b1; cpu_done = 1'b0; cnt_flat = '0;
    clear_stats();
    repeat (3) @(negedge clk);
    check(tx_din == 8'h00, "reset_tx_din", tx_din, 0);
    check(tx_start == 1'b0, "reset_tx_start", tx_start, 0);
    check(busy == 1'b0, "reset_busy", busy, 0);
    check(report_done == 1'b0, "reset_report_done", report_done, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Spurious tx_done in IDLE must not start anything
    clear_stats();
    repeat (4) begin
      spur_req = 1'b1;
      repeat (3) @(negedge clk);
    end
    check(start_cnt == 0, "spurious_idle_no_start", start_cnt, 0);
    check(busy == 1'b0, "spurious_idle_busy", busy, 0);

    // Vector table
    for (int k = 0; k < NUM_CNT; k++) vecs[0].cnt[k] = 32'(k + 1);
    vecs[0].exp_csum = 8'h08; vecs[0].rnd_delay = 1'b0;
    vecs[1].cnt = '0; vecs[1].cnt[0] = 32'hDEADBEEF;
    vecs[1].exp_csum = 8'h22; vecs[1].rnd_delay = 1'b0;
    vecs[2].cnt = '1;
    vecs[2].exp_csum = 8'h00; vecs[2].rnd_delay = 1'b1;
    vecs[3].cnt = '0; vecs[3].cnt[NUM_CNT-1] = 32'h12345678;
    vecs[3].exp_csum = 8'h08; vecs[3].rnd_delay = 1'b1;
    for (int v = 4; v < 6; v++) begin
      for (int k = 0; k < NUM_CNT; k++) vecs[v].cnt[k] = $urandom;
      vecs[v].exp_csum  = build_exp(vecs[v].cnt);
      vecs[v].rnd_delay = 1'b1;
    end
    for (int v = 0; v < 6; v++) begin
      clear_stats();
      tx_delay   = 10;
      rand_delay = vecs[v].rnd_delay;
      trig(vecs[v].cnt);
      wait_report($sformatf("vec%0d", v), 3000, 1'b0);
      check_frame($sformatf("vec%0d", v), vecs[v].cnt, vecs[v].exp_csum);
    end
    rand_delay = 1'b0;

    // Counters change every cycle after the trigger
    clear_stats();
    for (int k = 0; k < NUM_CNT; k++) c[k] = $urandom;
    trig(c);
    wait_report("scramble", 3000, 1'b1);
    check_frame("scramble", c, build_exp(c));

    // cpu_done held high, then re-pulsed mid-report
    clear_stats();
    tx_delay = 20;
    for (int k = 0; k < NUM_CNT; k++) c[k] = $urandom;
    @(negedge clk);
    cnt_flat = c;
    cpu_done = 1'b1;
    repeat (500) @(negedge clk);
    cpu_done = 1'b0;
    repeat (2) @(negedge clk);
    check(busy == 1'b1, "hold_busy_mid_report", busy, 1);
    cpu_done = 1'b1;
    repeat (3) @(negedge clk);
    cpu_done = 1'b0;
    wait_report("hold", 3000, 1'b0);
    repeat (300) @(negedge clk);
    check_frame("hold", c, build_exp(c));

    // Rising edge coincident with report_done is dropped
    clear_stats();
    tx_delay = 3;
    for (int k = 0; k < NUM_CNT; k++) c[k] = $urandom;
    trig(c);
    n = 0;
    while (report_done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(report_done === 1'b1, "coincident_report_done_seen", report_done, 1);
    cpu_done = 1'b1;
    repeat (40) @(negedge clk);
    check(start_cnt == NB + 2, "coincident_edge_dropped_starts", start_cnt, NB + 2);
    check(busy == 1'b0, "coincident_edge_dropped_busy", busy, 0);
    cpu_done = 1'b0;
    repeat (3) @(negedge clk);

    // Asynchronous reset while waiting on payload byte 5
    clear_stats();
    tx_delay = 10;
    for (int k = 0; k < NUM_CNT; k++) c[k] = $urandom;
    trig(c);
    n = 0;
    while (start_cnt < 7 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check(start_cnt == 7, "rst_at_idx5_starts", start_cnt, 7);
    check(busy == 1'b1, "rst_at_idx5_busy_before", busy, 1);
    #2;
    rst = 1'b1;
    tx_flush = 1'b1;
    #1;
    check(tx_din == 8'h00, "async_rst_tx_din", tx_din, 0);
    check(tx_start == 1'b0, "async_rst_tx_start", tx_start, 0);
    check(busy == 1'b0, "async_rst_busy", busy, 0);
    check(report_done == 1'b0, "async_rst_report_done", report_done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    clear_stats();
    for (int k = 0; k < NUM_CNT; k++) c[k] = $urandom;
    trig(c);
    wait_report("after_rst", 3000, 1'b0);
    check_frame("after_rst", c, build_exp(c));

    // One byte with a 1000-cycle tx_done delay
    clear_stats();
    tx_delay = 4;
    long_idx = 3;
    for (int k = 0; k < NUM_CNT; k++) c[k] = $urandom;
    trig(c);
    wait_report("long_wait", 3000, 1'b0);
    check_frame("long_wait", c, build_exp(c));
    long_idx = -1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
